fpu_result_capture: RTL and testbench
=====================================

# fpu_result_capture

Result-side collector for the pipelined floating-point add/subtract unit. It takes the unit's `ready`-qualified result stream and its flags, then tags each result with its issue-order sequence number. Results are buffered in a first-word-fall-through FIFO and drained to a downstream consumer, such as a memory writer or serial dump, through a valid/ack handshake. It replaces simulation-only result logging with synthesizable capture, so vector runs can execute on hardware.

## Interface
- `W`, 32: IEEE word width (64 for double).
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CW`, 16: width of the tag and of all counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a capture run.
- `cfg_count` in CW: number of results expected in the run; sampled on `start`.
- `ready` in 1: FPU result-valid strobe, one cycle per result.
- `final_result_ieee` in W: FPU result.
- `overflow_flag`, `underflow_flag`, `zero_flag` in 1 each: FPU flags, valid with `ready`.
- `out_valid` out 1: the FIFO head is valid.
- `out_data` out W: head result.
- `out_flags` out 3: head flags as {overflow, underflow, zero}.
- `out_tag` out CW: head sequence number; the first result of a run is 0.
- `out_ack` in 1: consumer accepts the head this cycle.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `captured_cnt` out CW: results written into the FIFO this run.
- `dropped_cnt` out CW: results lost because the FIFO was full; saturates at all-ones.
- `lost` out 1: sticky; set on any drop, cleared on `start`.

## Operation
- States:
  - **IDLE**: `ready` is ignored. `start` moves to RUN, or directly to DONE if `cfg_count`=0.
  - **RUN**: each `ready` is one received result. When received = `cfg_count` − 1 and `ready`=1, move to DRAIN after that capture.
  - **DRAIN**: `ready` is ignored and not counted. Move to DONE on the cycle the FIFO becomes empty.
  - **DONE**: `done`=1. `start` begins a new run.
- Effects of `start`, accepted in IDLE or DONE only (ignored in RUN and DRAIN):
  - latch `cfg_count`;
  - clear `captured_cnt`, `dropped_cnt`, `lost` and the sequence counter;
  - do not flush the FIFO.
- Received count = `captured_cnt` + `dropped_cnt`. It uses a separate unsaturated internal counter of CW bits.
- Every received result consumes one sequence number, including dropped ones. Gaps in `out_tag` therefore identify lost results.
- Push rule: a result is pushed if the FIFO is not full, or if a pop happens in the same cycle (`out_valid` && `out_ack`).
  - A full FIFO with a simultaneous pop accepts the push. It stays full and counts a capture, not a drop.
  - Otherwise the result is dropped: `dropped_cnt`++ (saturating) and `lost`←1.
- Pop rule: a pop occurs when `out_valid` && `out_ack`. `out_ack` with `out_valid`=0 has no effect.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full: the MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.
- Entry layout: {tag, flags, data}, CW+3+W bits.
- `out_*` hold stable while `out_valid`=1 and `out_ack`=0.

## Timing
- Reset (`rst`=0 at a rising edge) is synchronous and overrides everything, including reset mid-run. After reset:
  - state is IDLE;
  - `out_valid`, `busy`, `done`, `lost` are 0;
  - all counters are 0;
  - FIFO is empty;
  - `out_data`, `out_flags`, `out_tag` are 0.
- Capture latency: a `ready` sampled at edge k into an empty FIFO gives `out_valid`=1 with that entry after edge k. Zero bubbles.
- Throughput: one push and one pop per cycle, sustained.
- After a pop at edge k, the next entry is presented after edge k, or `out_valid` falls if the FIFO is empty.
- `busy` rises after the `start` edge.
- `done` rises after the edge on which the last pop empties the FIFO in DRAIN. With `cfg_count`=0, `done` rises after the `start` edge.
- `start` and `ready` in the same IDLE cycle: `start` takes effect and that `ready` is ignored.

## Test plan
- **Basic run.** Reset, then `start` with `cfg_count`=4. Send 4 `ready` pulses with results 3F800000, 40000000, 00000000 (zero=1), 7F800000 (ovf=1), with `out_ack` held at 1. Required: 4 pops with tags 0–3 and matching data and flags, `captured_cnt`=4, `dropped_cnt`=0, then `done`=1.
- **Overflow/drop.** `DEPTH`=16, `cfg_count`=20, `out_ack`=0, 20 back-to-back `ready` pulses. Required: `captured_cnt`=16, `dropped_cnt`=4, `lost`=1, FIFO full. Then assert `out_ack`: tags 0–15 drain and `done` rises after the 16th pop.
- **Full with simultaneous push and pop.** Fill the FIFO to 16, then one cycle with both `ready` and `out_ack`. Required: no drop, count stays 16, tag 16 appears as the last entry.
- **Backpressure.** Toggle `out_ack` randomly during a 100-result run at 1 result per 3 cycles. Required: all 100 tags in order, no gaps, `out_*` stable while `out_ack`=0.
- **Control edge cases.** First, `start` with `cfg_count`=0: required `done`=1 after one edge. Second, `start` mid-RUN: required no effect. Third, `rst`=0 mid-RUN with 5 entries queued: required all outputs at reset values on the next cycle and FIFO empty.

Source files
------------

// File: rtl/fpu_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_capture
// Purpose  : Collects the ready-qualified result stream of the pipelined FP
//            add/sub unit, tags each result with its issue-order sequence
//            number and buffers it in a first-word-fall-through FIFO that a
//            downstream consumer drains through a valid/ack handshake.
// Ports    : clk, rst (sync, active-low)
//            start, cfg_count             - run control
//            ready, final_result_ieee,
//            overflow_flag, underflow_flag,
//            zero_flag                    - FPU result stream
//            out_valid, out_data, out_flags,
//            out_tag, out_ack             - consumer handshake
//            busy, done, captured_cnt,
//            dropped_cnt, lost            - status
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_capture #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_count,
  input  logic          ready,
  input  logic [W-1:0]  final_result_ieee,
  input  logic          overflow_flag,
  input  logic          underflow_flag,
  input  logic          zero_flag,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [2:0]    out_flags,
  output logic [CW-1:0] out_tag,
  input  logic          out_ack,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] captured_cnt,
  output logic [CW-1:0] dropped_cnt,
  output logic          lost
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + 3 + W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cfg_q;
  logic [CW-1:0] rcv_cnt;     // unsaturated; doubles as the sequence number
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  logic empty, full, pop, start_ok, rcv, push, drop, last, empty_next;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ack;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rcv      = (state_q == S_RUN) && ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = rcv && (!full || pop);
  assign drop     = rcv && !push;
  assign last     = (rcv_cnt == cfg_q - CW'(1));

  // Only pops occur in DRAIN, so the FIFO empties when the last entry leaves.
  assign empty_next = empty || (pop && ((rd_ptr + (AW+1)'(1)) == wr_ptr));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (cfg_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rcv && last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty_next) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, pointers and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_q        <= '0;
      rcv_cnt      <= '0;
      captured_cnt <= '0;
      dropped_cnt  <= '0;
      lost         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      if (start_ok) begin
        // The FIFO is deliberately left intact across runs.
        cfg_q        <= cfg_count;
        rcv_cnt      <= '0;
        captured_cnt <= '0;
        dropped_cnt  <= '0;
        lost         <= 1'b0;
      end else begin
        if (rcv)  rcv_cnt <= rcv_cnt + CW'(1);
        if (push) captured_cnt <= captured_cnt + CW'(1);
        if (drop) begin
          lost <= 1'b1;
          if (dropped_cnt != '1) dropped_cnt <= dropped_cnt + CW'(1);
        end
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {rcv_cnt, overflow_flag, underflow_flag, zero_flag,
                              final_result_ieee};
  end

  // --------------------------------------------------------------------------
  // Outputs: head is read combinationally for zero-bubble fall-through and is
  // forced to zero while empty so idle outputs read as zero.
  // --------------------------------------------------------------------------
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = out_valid ? head[W-1:0]       : '0;
  assign out_flags = out_valid ? head[W+2:W]       : '0;
  assign out_tag   = out_valid ? head[EW-1:W+3]    : '0;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_capture
// Purpose  : Directed self-checking bench for fpu_result_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_capture;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_count;
  logic        ready;
  logic [31:0] final_result_ieee;
  logic        overflow_flag, underflow_flag, zero_flag;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic [15:0] out_tag;
  logic        out_ack;
  logic        busy, done;
  logic [15:0] captured_cnt, dropped_cnt;
  logic        lost;

  int checks   = 0;
  int failures = 0;

  fpu_result_capture #(.W(32), .DEPTH(16), .CW(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_count         (cfg_count),
    .ready             (ready),
    .final_result_ieee (final_result_ieee),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag),
    .zero_flag         (zero_flag),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_flags         (out_flags),
    .out_tag           (out_tag),
    .out_ack           (out_ack),
    .busy              (busy),
    .done              (done),
    .captured_cnt      (captured_cnt),
    .dropped_cnt       (dropped_cnt),
    .lost              (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] fl);
    ready             = 1'b1;
    final_result_ieee = d;
    {overflow_flag, underflow_flag, zero_flag} = fl;
  endtask

  function automatic logic [31:0] bp_data(input int t);
    return 32'hC000_0000 | t;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] vec_d [4];
  logic [2:0]  vec_f [4];

  initial begin
    int exp_tag, sent, cyc;
    logic hold;
    logic [15:0] h_tag;
    logic [31:0] h_data;

    vec_d[0] = 32'h3F80_0000; vec_f[0] = 3'b000;
    vec_d[1] = 32'h4000_0000; vec_f[1] = 3'b000;
    vec_d[2] = 32'h0000_0000; vec_f[2] = 3'b001;
    vec_d[3] = 32'h7F80_0000; vec_f[3] = 3'b100;

    rst = 1'b0; start = 1'b0; cfg_count = '0; ready = 1'b0;
    final_result_ieee = '0; overflow_flag = 1'b0; underflow_flag = 1'b0;
    zero_flag = 1'b0; out_ack = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lost", lost, 0);
    check("rst_capt", captured_cnt, 0);
    check("rst_drop", dropped_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", out_flags, 0);
    check("rst_tag", out_tag, 0);
    rst = 1'b1;

    // ---------------- basic run ----------------
    @(negedge clk);
    start = 1'b1; cfg_count = 16'd4; out_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("basic_busy", busy, 1);
    check("basic_nodone", done, 0);
    for (int i = 0; i < 4; i++) begin
      send(vec_d[i], vec_f[i]);
      @(negedge clk);
      check("basic_valid", out_valid, 1);
      check("basic_tag", out_tag, i);
      check("basic_data", out_data, vec_d[i]);
      check("basic_flags", out_flags, vec_f[i]);
    end
    ready = 1'b0;
    check("basic_drain_busy", busy, 1);
    check("basic_drain_nodone", done, 0);
    @(negedge clk);
    check("basic_done", done, 1);
    check("basic_empty", out_valid, 0);
    check("basic_capt", captured_cnt, 4);
    check("basic_drop", dropped_cnt, 0);

    // ---------------- overflow / drop ----------------
    out_ack = 1'b0; start = 1'b1; cfg_count = 16'd20;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(32'h1000 + i, 3'(i));
      @(negedge clk);
    end
    ready = 1'b0;
    check("ovf_capt", captured_cnt, 16);
    check("ovf_drop", dropped_cnt, 4);
    check("ovf_lost", lost, 1);
    check("ovf_busy", busy, 1);
    out_ack = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("ovf_tag", out_tag, j);
      check("ovf_data", out_data, 32'h1000 + j);
      check("ovf_nodone", done, 0);
      @(negedge clk);
    end
    check("ovf_done", done, 1);
    check("ovf_empty", out_valid, 0);
    check("ovf_lost_sticky", lost, 1);

    // ---------------- full with simultaneous push and pop ----------------
    out_ack = 1'b0; start = 1'b1; cfg_count = 16'd17;
    @(negedge clk);
    start = 1'b0;
    check("fpp_lost_clr", lost, 0);
    for (int i = 0; i < 16; i++) begin
      send(32'h2000 + i, 3'b000);
      @(negedge clk);
    end
    check("fpp_full_capt", captured_cnt, 16);
    check("fpp_head0", out_tag, 0);
    send(32'h2010, 3'b010);
    out_ack = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("fpp_drop", dropped_cnt, 0);
    check("fpp_lost", lost, 0);
    check("fpp_capt", captured_cnt, 17);
    for (int j = 1; j <= 16; j++) begin
      check("fpp_tag", out_tag, j);
      check("fpp_data", out_data, 32'h2000 + j);
      @(negedge clk);
    end
    check("fpp_done", done, 1);
    check("fpp_empty", out_valid, 0);

    // ---------------- backpressure ----------------
    out_ack = 1'b0; start = 1'b1; cfg_count = 16'd100;
    @(negedge clk);
    start = 1'b0;
    exp_tag = 0; sent = 0; cyc = 0; hold = 1'b0; h_tag = '0; h_data = '0;
    while (exp_tag < 100 && cyc < 3000) begin
      if (hold) begin
        check("bp_hold_tag", out_tag, h_tag);
        check("bp_hold_data", out_data, h_data);
      end
      out_ack = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ack) begin
        check("bp_tag", out_tag, exp_tag);
        check("bp_data", out_data, bp_data(exp_tag));
        exp_tag++;
      end
      hold   = out_valid && !out_ack;
      h_tag  = out_tag;
      h_data = out_data;
      if ((cyc % 3) == 0 && sent < 100) begin
        send(bp_data(sent), 3'(sent));
        sent++;
      end else begin
        ready = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    ready = 1'b0; out_ack = 1'b0;
    check("bp_all_popped", exp_tag, 100);
    check("bp_done", done, 1);
    check("bp_capt", captured_cnt, 100);
    check("bp_drop", dropped_cnt, 0);

    // ---------------- control edge cases ----------------
    start = 1'b1; cfg_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);

    start = 1'b1; cfg_count = 16'd10;
    @(negedge clk);
    start = 1'b0;
    send(32'hA, 3'b000);
    @(negedge clk);
    send(32'hB, 3'b000);
    @(negedge clk);
    ready = 1'b0; start = 1'b1; cfg_count = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("midstart_busy", busy, 1);
    check("midstart_capt", captured_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      send(32'hC + i, 3'b000);
      @(negedge clk);
    end
    ready = 1'b0;
    check("midstart_capt5", captured_cnt, 5);
    check("midstart_valid", out_valid, 1);
    check("midstart_head", out_data, 32'hA);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_lost", lost, 0);
    check("midrst_capt", captured_cnt, 0);
    check("midrst_drop", dropped_cnt, 0);
    check("midrst_data", out_data, 0);
    check("midrst_tag", out_tag, 0);
    check("midrst_flags", out_flags, 0);
    @(negedge clk);
    check("midrst_still_empty", out_valid, 0);

    // start and ready together in IDLE: the ready is ignored
    start = 1'b1; cfg_count = 16'd1;
    send(32'hDEAD, 3'b111);
    @(negedge clk);
    start = 1'b0; ready = 1'b0;
    check("sr_valid", out_valid, 0);
    check("sr_capt", captured_cnt, 0);
    check("sr_busy", busy, 1);
    send(32'hBEEF, 3'b010);
    @(negedge clk);
    ready = 1'b0;
    check("sr_tag", out_tag, 0);
    check("sr_data", out_data, 32'hBEEF);
    check("sr_flags", out_flags, 3'b010);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check("sr_done", done, 1);
    check("sr_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
